// File: rtl/cdclib_fifo_arb_pkg.sv
// Shared types and helpers for the cdclib FIFO write/read arbiters.
// Holds the arbiter state encoding and an elaboration-time clog2 for ID width checks.
package cdclib_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Returns 1 when idw is the exact ID width for nreq requesters.
  function automatic bit idw_ok(input int nreq, input int idw);
    return idw == clog2(nreq);
  endfunction

endpackage

// File: rtl/cdclib_rr_pick.sv
// Round-robin picker: first set bit of req searching ptr, ptr+1, ... mod N.
// Ports: req (N), ptr (W) in; found, idx (W) out. Purely combinational.
module cdclib_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;

  // Rotate so ptr sits at bit 0, fixed-priority pick, then un-rotate.
  always_comb begin
    int base;
    int off;
    int j;
    base = (int'(ptr) < N) ? int'(ptr) : 0;
    rot  = '0;
    for (int k = 0; k < N; k++) begin
      j = base + k;
      if (j >= N) j = j - N;
      rot[k] = req[j];
    end
    found = |rot;
    off = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    j = base + off;
    if (j >= N) j = j - N;
    idx = W'(j);
  end

endmodule

// File: rtl/cdclib_fifo_wr_arb.sv
// Round-robin packet arbiter sharing one async-FIFO write port among NREQ sources.
// Ports: wr_clk/wr_rst_n; req_valid/data/last/ready per source; r_maxburst cap;
// fifo_wr_full/pfull in; fifo_wr_en, fifo_wr_data {id,payload}, grant_id, busy out.
module cdclib_fifo_wr_arb
  import cdclib_fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int IDW    = 2,
  parameter int BCW    = 4
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic [BCW-1:0]         r_maxburst,
  input  logic                   fifo_wr_full,
  input  logic                   fifo_wr_pfull,
  output logic                   fifo_wr_en,
  output logic [IDW+DWIDTH-1:0]  fifo_wr_data,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

  if (!idw_ok(NREQ, IDW)) begin : g_idw_bad
    $error("IDW must equal clog2(NREQ)");
  end

  arb_state_e      state;
  logic [IDW-1:0]  rr_ptr;
  logic [BCW-1:0]  beat_cnt;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic            g_valid;
  logic            g_last;
  logic [DWIDTH-1:0] g_data;
  logic            acc;
  logic            cap_hit;
  logic            burst_end;

  cdclib_rr_pick #(
    .N(NREQ),
    .W(IDW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    g_valid = req_valid[grant_id];
    g_last  = req_last[grant_id];
    g_data  = req_data[grant_id*DWIDTH +: DWIDTH];
    acc     = (state == BURST) & ~fifo_wr_full & g_valid;
    req_ready = '0;
    if (state == BURST && !fifo_wr_full)
      req_ready[grant_id] = 1'b1;
    // Cap compares the post-increment count so the capping beat ends the burst.
    cap_hit = (r_maxburst != '0) &&
              (({1'b0, beat_cnt} + (BCW+1)'(1)) == {1'b0, r_maxburst});
    burst_end    = acc & (g_last | cap_hit);
    fifo_wr_en   = acc;
    fifo_wr_data = {grant_id, g_data};
  end

  assign busy = (state == BURST);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found && !fifo_wr_pfull) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (acc && beat_cnt != '1)
            beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            rr_ptr <= (grant_id == IDW'(NREQ - 1)) ?
                      '0 : grant_id + 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdclib_fifo_wr_arb.sv
// Bench for cdclib_fifo_wr_arb: vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_cdclib_fifo_wr_arb;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int IDW    = 2;
  localparam int BCW    = 4;
  localparam int WW     = IDW + DWIDTH;

  logic                   wr_clk = 1'b0;
  logic                   wr_rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [BCW-1:0]         r_maxburst;
  logic                   fifo_wr_full;
  logic                   fifo_wr_pfull;
  logic                   fifo_wr_en;
  logic [WW-1:0]          fifo_wr_data;
  logic [IDW-1:0]         grant_id;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  always #5 wr_clk = ~wr_clk;

  cdclib_fifo_wr_arb #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .IDW(IDW), .BCW(BCW)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .r_maxburst   (r_maxburst),
    .fifo_wr_full (fifo_wr_full),
    .fifo_wr_pfull(fifo_wr_pfull),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: owner -1 means no grant held.
  int m_owner, m_ptr, m_gid, m_beats;

  task automatic m_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_beats = 0;
  endtask

  function automatic logic m_en();
    if (m_owner < 0) return 1'b0;
    return !fifo_wr_full && req_valid[m_owner];
  endfunction

  task automatic m_check();
    logic [NREQ-1:0] er;
    logic [31:0] ed;
    er = '0;
    if (m_owner >= 0 && !fifo_wr_full) er[m_owner] = 1'b1;
    chk("m_ready", req_ready, er);
    chk("m_en", fifo_wr_en, m_en());
    chk("m_busy", busy, m_owner >= 0);
    chk("m_gid", grant_id, m_gid);
    if (m_en()) begin
      ed = (m_owner << DWIDTH) | req_data[m_owner*DWIDTH +: DWIDTH];
      chk("m_data", fifo_wr_data, ed);
    end
  endtask

  task automatic m_update();
    int i;
    if (m_owner < 0) begin
      if (req_valid != '0 && !fifo_wr_pfull) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (req_valid[i]) begin
            m_owner = i;
            m_gid   = i;
            m_beats = 0;
            break;
          end
        end
      end
    end else if (m_en()) begin
      m_beats++;
      if (req_last[m_owner] ||
          (r_maxburst != '0 && m_beats == int'(r_maxburst))) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  logic [NREQ-1:0] acc_v;
  logic [NREQ-1:0] rdy_s;
  logic            en_s;
  logic [WW-1:0]   cap_q[$];

  task automatic cyc();
    @(negedge wr_clk);
    m_check();
    acc_v = req_ready & req_valid;
    rdy_s = req_ready;
    en_s  = fifo_wr_en;
    if (fifo_wr_en) cap_q.push_back(fifo_wr_data);
    @(posedge wr_clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n      = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    fifo_wr_full  = 1'b0;
    fifo_wr_pfull = 1'b0;
    r_maxburst    = '0;
    req_data      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    repeat (2) @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    m_reset();
    cap_q.delete();
    acc_v = '0;
  endtask

  typedef struct {
    logic [3:0] v, l;
    logic       f, pf;
    logic [3:0] mb, rdy;
    logic       en, bsy;
    logic [1:0] gid;
  } vec_t;

  function automatic vec_t mk(
    input logic [3:0] v, input logic [3:0] l,
    input logic f, input logic pf, input logic [3:0] mb,
    input logic [3:0] rdy, input logic en, input logic bsy,
    input logic [1:0] gid);
    vec_t t;
    t.v = v; t.l = l; t.f = f; t.pf = pf; t.mb = mb;
    t.rdy = rdy; t.en = en; t.bsy = bsy; t.gid = gid;
    return t;
  endfunction

  vec_t tbl[26];
  int   left[NREQ];

  task automatic rnd_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (acc_v[i]) left[i]--;
      if (left[i] == 0 && $urandom_range(3) == 0)
        left[i] = $urandom_range(6, 1);
      req_valid[i] = (left[i] > 0) && ($urandom_range(9) < 7);
      req_last[i]  = (left[i] == 1);
      req_data[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
    end
    fifo_wr_full  = ($urandom_range(99) < 15);
    fifo_wr_pfull = ($urandom_range(99) < 20);
    if (m_owner < 0 && $urandom_range(19) == 0) begin
      case ($urandom_range(3))
        0: r_maxburst = 4'd0;
        1: r_maxburst = 4'd2;
        2: r_maxburst = 4'd3;
        default: r_maxburst = 4'd5;
      endcase
    end
  endtask

  initial begin
    logic [WW-1:0] w;
    int n1, n3, bad, nb;
    wr_rst_n      = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    fifo_wr_full  = 1'b0;
    fifo_wr_pfull = 1'b0;
    r_maxburst    = '0;
    req_data      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    acc_v         = '0;
    m_reset();

    @(negedge wr_clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;

    tbl[0]  = mk(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 1, 1, 2);
    tbl[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 1, 2);
    tbl[3]  = mk(4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 1, 1, 2);
    tbl[4]  = mk(4'b0100, 4'b0100, 0, 0, 0, 4'b0100, 1, 1, 2);
    tbl[5]  = mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);
    tbl[6]  = mk(4'b0001, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 2);
    tbl[7]  = mk(4'b0001, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 2);
    tbl[8]  = mk(4'b0001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 2);
    tbl[9]  = mk(4'b0001, 4'b0000, 0, 1, 0, 4'b0001, 1, 1, 0);
    tbl[10] = mk(4'b0001, 4'b0000, 1, 1, 0, 4'b0000, 0, 1, 0);
    tbl[11] = mk(4'b0001, 4'b0001, 0, 1, 0, 4'b0001, 1, 1, 0);
    tbl[12] = mk(4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    tbl[13] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0010, 1, 1, 1);
    tbl[14] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 1);
    tbl[15] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0100, 1, 1, 2);
    tbl[16] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 2);
    tbl[17] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b1000, 1, 1, 3);
    tbl[18] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 3);
    tbl[19] = mk(4'b1111, 4'b1111, 0, 0, 0, 4'b0001, 1, 1, 0);
    tbl[20] = mk(4'b1010, 4'b0000, 0, 0, 2, 4'b0000, 0, 0, 0);
    tbl[21] = mk(4'b1010, 4'b0000, 0, 0, 2, 4'b0010, 1, 1, 1);
    tbl[22] = mk(4'b1010, 4'b0000, 0, 0, 2, 4'b0010, 1, 1, 1);
    tbl[23] = mk(4'b1010, 4'b0000, 0, 0, 2, 4'b0000, 0, 0, 1);
    tbl[24] = mk(4'b1010, 4'b1000, 0, 0, 2, 4'b1000, 1, 1, 3);
    tbl[25] = mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 3);

    for (int r = 0; r < 26; r++) begin
      req_valid     = tbl[r].v;
      req_last      = tbl[r].l;
      fifo_wr_full  = tbl[r].f;
      fifo_wr_pfull = tbl[r].pf;
      r_maxburst    = tbl[r].mb;
      @(negedge wr_clk);
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_en", r), fifo_wr_en, tbl[r].en);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].gid);
      if (tbl[r].en)
        chk($sformatf("tbl%0d_data", r), fifo_wr_data,
            {tbl[r].gid, 6'h28, tbl[r].gid});
      @(posedge wr_clk);
      #1;
    end

    // Burst cap: source 1 streams without last, source 3 waits.
    do_reset();
    req_valid  = 4'b1010;
    r_maxburst = 4'd4;
    repeat (10) cyc();
    n1 = 0; n3 = 0; bad = 0;
    foreach (cap_q[k]) begin
      w = cap_q[k];
      if (w[WW-1:DWIDTH] == 2'd1) n1++;
      if (w[WW-1:DWIDTH] == 2'd3) n3++;
      if (w[WW-1:DWIDTH] != ((k < 4) ? 2'd1 : 2'd3)) bad++;
    end
    chk("cap_n1", n1, 4);
    chk("cap_n3", n3, 4);
    chk("cap_order", bad, 0);

    // Full stall for 5 cycles in the middle of a 4-beat packet.
    do_reset();
    req_valid = 4'b0001;
    nb = 0;
    for (int c = 0; c < 20 && nb < 4; c++) begin
      req_data[DWIDTH-1:0] = DWIDTH'(16 + nb);
      req_last[0]  = (nb == 3);
      fifo_wr_full = (c >= 3 && c < 8);
      cyc();
      if (fifo_wr_full) begin
        chk("stall_ready", rdy_s, 0);
        chk("stall_en", en_s, 0);
      end
      if (acc_v[0]) nb++;
    end
    fifo_wr_full = 1'b0;
    chk("stall_beats", nb, 4);
    chk("stall_words", cap_q.size(), 4);
    bad = 0;
    foreach (cap_q[k])
      if (cap_q[k] !== WW'(16 + k)) bad++;
    chk("stall_order", bad, 0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req_valid = 4'b1000;
    repeat (3) cyc();
    chk("pre_rst_gid", grant_id, 3);
    chk("pre_rst_busy", busy, 1);
    #2 wr_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_en", fifo_wr_en, 0);
    m_reset();
    cap_q.delete();
    @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    repeat (2) cyc();
    chk("post_rst_words", cap_q.size(), 1);
    w = (cap_q.size() > 0) ? cap_q[0] : '1;
    chk("post_rst_tag", w[WW-1:DWIDTH], 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      rnd_drive();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdclib_fifo_wr_arb.md
Name: cdclib_fifo_wr_arb

Overview:
Round-robin write-port arbiter that shares one cdclib_async_fifo write port among NREQ requesters in the write clock domain.
Grants whole packets (bursts) and tags each written word with the source ID, so the read side can demultiplex.
Respects the FIFO's wr_full and wr_pfull flags and bounds each burst with a programmable maximum length.
Sits between requester logic and the FIFO; drives the FIFO's wr_en and wr_data directly.

Parameters:
NREQ, 4, number of requesters (2..16)
DWIDTH, 8, payload width per requester
IDW, 2, source-ID width; must equal clog2(NREQ)
BCW, 4, burst-counter width; maximum burst is 2^BCW-1 beats

Ports:
wr_clk  in  1  write-domain clock
wr_rst_n  in  1  write-domain reset; asynchronous assert, active-low
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*DWIDTH  per-requester payload; requester i uses bits [i*DWIDTH +: DWIDTH]
req_last  in  NREQ  beat is last of packet
req_ready  out  NREQ  beat accepted this cycle when valid&ready
r_maxburst  in  BCW  max beats per grant; 0 means unlimited (burst ends on last only)
fifo_wr_full  in  1  FIFO wr_full
fifo_wr_pfull  in  1  FIFO wr_pfull
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_data  out  IDW+DWIDTH  to FIFO wr_data, {grant_id, payload}
grant_id  out  IDW  currently or last granted requester
busy  out  1  high in BURST state

Behaviour:
- Reset (wr_rst_n=0, async): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0. Consequently req_ready=0 and fifo_wr_en=0 during reset and in the first cycle after.
- States are IDLE and BURST.
- IDLE:
  - If |req_valid and !fifo_wr_pfull: pick the first valid index searching rr_ptr, rr_ptr+1, … mod NREQ.
  - Register the pick into grant_id, clear beat_cnt, go to BURST.
  - This is a 1-cycle arbitration latency; no beat is accepted in IDLE.
  - pfull blocks new grants only; it never interrupts a burst.
- BURST:
  - req_ready[i] = (i==grant_id) & !fifo_wr_full. All other ready bits are 0.
  - acc = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_en = acc (combinational).
  - fifo_wr_data = {grant_id, req_data[grant_id]} (combinational; don't-care when fifo_wr_en=0).
  - On acc: beat_cnt increments, saturating at 2^BCW-1.
  - Burst ends on an accepted beat with req_last=1, or when r_maxburst!=0 and beat_cnt+1==r_maxburst.
  - End of burst: rr_ptr = (grant_id+1) mod NREQ, go to IDLE.
- Stalls inside a burst:
  - Granted requester deasserts valid: arbiter holds the grant; there is no timeout.
  - fifo_wr_full=1: ready drops, nothing is written, burst holds.
- Overflow safety: the FIFO also gates wr_en & ~wr_full. The arbiter counts a beat only when !fifo_wr_full, so arbiter and FIFO pointer never disagree.
- FIFO programming: wr_full lags numdata by one cycle, so r_full must leave at least 1 entry of margin. This is a system programming rule; the arbiter does not enforce it.
- r_maxburst is sampled every cycle. Software changes it only while busy=0.
- Reset mid-burst: partial packet is abandoned. The FIFO shares wr_rst_n, so no orphan words remain on the write side.
- Width rules:
  - rr_ptr wrap uses explicit compare-to-(NREQ-1), not power-of-2 masking.
  - Out-of-range indices never win arbitration.

Decomposition:
- Package cdclib_fifo_arb_pkg holds:
  - state enum (IDLE=1'b0, BURST=1'b1)
  - clog2 function for IDW checking
  - elaboration assertion IDW==clog2(NREQ)
- Sub-module cdclib_rr_pick (combinational): inputs req vector and rr_ptr; outputs found and index.
  - Implement as a rotate, fixed-priority pick, then un-rotate.
  - Also reusable on the read side.

Test Plan:
- Basic handshake: only req 2 valid, 3-beat packet with last on beat 3, r_maxburst=0. Required response:
  - busy rises 1 cycle after valid.
  - Exactly 3 fifo_wr_en pulses with data tag 2'd2.
  - Then IDLE with rr_ptr=3.
- Fairness: all 4 requesters continuously valid, 1-beat packets. Grants cycle 0,1,2,3,0…, each followed by 1 IDLE cycle; 8 words in 16 cycles.
- Burst cap: req 1 streams with no last, r_maxburst=4, req 3 valid. Required response: 4 beats tagged 1, then a grant to 3; beat_cnt never exceeds 4.
- Full stall: force fifo_wr_full=1 for 5 cycles mid-burst. Required response: req_ready=0 and fifo_wr_en=0 for those 5 cycles; burst resumes with no lost or duplicated beat, and the scoreboard matches the FIFO read-out.
- Pfull gating: fifo_wr_pfull=1 while in IDLE with requests pending. Required response: no grant. Then assert pfull mid-burst: the burst completes to last.
- Reset mid-burst: assert wr_rst_n=0 after beat 2 of a 5-beat packet. Required response: all outputs go to reset values immediately; after release, arbitration restarts from requester 0.
